// File: rtl/pit_bus_master.sv
// Bus master for an 8254 programmable interval timer: turns one command into a
// sequence of timed 8-bit CS/RD/WR bus cycles and returns read-back data.
module pit_bus_master #(
    parameter int STROBE_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_counter,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [7:0]  rsp_status,
    output logic [1:0]  A,
    output logic        CS,
    output logic        RD,
    output logic        WR,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, DONE} state_t;

    localparam logic [1:0] OP_PROGRAM   = 2'b00;
    localparam logic [1:0] OP_LATCH     = 2'b01;
    localparam logic [1:0] OP_READBACK  = 2'b10;
    localparam logic [1:0] OP_WRITE     = 2'b11;

    localparam logic [1:0] DEST_NONE    = 2'd0;
    localparam logic [1:0] DEST_STATUS  = 2'd1;
    localparam logic [1:0] DEST_LO      = 2'd2;
    localparam logic [1:0] DEST_HI      = 2'd3;

    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVERY_CYCLES - 1);

    state_t state, next_state;

    logic [3:0]      cnt;
    logic [1:0]      step;
    logic [2:0]      seq_len;
    logic [3:0]      seq_wr;
    logic [3:0][1:0] seq_addr;
    logic [3:0][1:0] seq_dest;
    logic [3:0][7:0] seq_data;
    logic            err_flag;
    logic            has_read;
    logic            is_readback;
    logic            is_program;
    logic [1:0]      prog_counter;
    logic [1:0]      prog_rw;
    logic [2:0][1:0] shadow_rw;
    logic [15:0]     cap_data;
    logic [7:0]      cap_status;

    logic            accept;
    logic            strobe_done;
    logic            recover_done;
    logic            last_step;

    logic [1:0]      cur_shadow;
    logic [1:0]      eff_rw;
    logic [2:0]      select;
    logic            count_write;
    logic            new_err;
    logic [2:0]      n;
    logic [2:0]      new_len;
    logic [3:0]      new_wr;
    logic [3:0][1:0] new_addr;
    logic [3:0][1:0] new_dest;
    logic [3:0][7:0] new_data;

    assign cmd_ready    = (state == IDLE) && !rst;
    assign accept       = cmd_valid && cmd_ready;
    assign strobe_done  = (cnt == STROBE_LAST);
    assign recover_done = (cnt == RECOVER_LAST);
    assign last_step    = ({1'b0, step} == (seq_len - 3'd1));

    // Decode the incoming command into a list of up to four byte transfers;
    // the list is captured on acceptance and replayed one bus cycle per step.
    always_comb begin
        cur_shadow = 2'b00;
        case (cmd_counter)
            2'd0:    cur_shadow = shadow_rw[0];
            2'd1:    cur_shadow = shadow_rw[1];
            2'd2:    cur_shadow = shadow_rw[2];
            default: cur_shadow = 2'b00;
        endcase
        eff_rw      = (cmd_op == OP_PROGRAM) ? cmd_rw : cur_shadow;
        new_err     = (cmd_counter == 2'd3) || (eff_rw == 2'b00);
        select      = 3'b001 << cmd_counter;
        count_write = (cmd_op == OP_PROGRAM) || (cmd_op == OP_WRITE);
        new_wr      = '0;
        new_addr    = '0;
        new_dest    = '0;
        new_data    = '0;
        n           = 3'd0;

        if (cmd_op != OP_WRITE) begin
            new_wr[0]   = 1'b1;
            new_addr[0] = 2'b11;
            case (cmd_op)
                OP_PROGRAM: new_data[0] = {cmd_counter, cmd_rw, cmd_mode, cmd_bcd};
                OP_LATCH:   new_data[0] = {cmd_counter, 2'b00, 4'b0000};
                default:    new_data[0] = {2'b11, 1'b0, 1'b0, select, 1'b0};
            endcase
            n = 3'd1;
        end

        if (cmd_op == OP_READBACK) begin
            new_addr[n[1:0]] = cmd_counter;
            new_dest[n[1:0]] = DEST_STATUS;
            n = n + 3'd1;
        end

        new_wr[n[1:0]]   = count_write;
        new_addr[n[1:0]] = cmd_counter;
        new_data[n[1:0]] = (eff_rw == 2'b10) ? cmd_count[15:8] : cmd_count[7:0];
        if (!count_write)
            new_dest[n[1:0]] = (eff_rw == 2'b10) ? DEST_HI : DEST_LO;
        n = n + 3'd1;

        if (eff_rw == 2'b11) begin
            new_wr[n[1:0]]   = count_write;
            new_addr[n[1:0]] = cmd_counter;
            new_data[n[1:0]] = cmd_count[15:8];
            if (!count_write)
                new_dest[n[1:0]] = DEST_HI;
            n = n + 3'd1;
        end

        new_len = n;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = new_err ? DONE : SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  if (strobe_done) next_state = HOLD;
            HOLD:    next_state = RECOVER;
            RECOVER: if (recover_done) next_state = last_step ? DONE : SETUP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        CS        = 1'b1;
        RD        = 1'b1;
        WR        = 1'b1;
        A         = 2'b00;
        D_out     = 8'h00;
        D_oe      = 1'b0;
        rsp_valid = (state == DONE) && !rst;
        rsp_err   = (state == DONE) && !rst && err_flag;
        if (state == SETUP || state == STROBE || state == HOLD) begin
            CS = 1'b0;
            A  = seq_addr[step];
            if (seq_wr[step]) begin
                D_oe  = 1'b1;
                D_out = seq_data[step];
            end
            if (state == STROBE) begin
                WR = !seq_wr[step];
                RD = seq_wr[step];
            end
        end
    end

    // Sequencing and capture: read bytes land in staging registers so the
    // visible response only changes at a completed, read-bearing command.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 4'd0;
            step         <= 2'd0;
            seq_len      <= 3'd0;
            seq_wr       <= '0;
            seq_addr     <= '0;
            seq_dest     <= '0;
            seq_data     <= '0;
            err_flag     <= 1'b0;
            has_read     <= 1'b0;
            is_readback  <= 1'b0;
            is_program   <= 1'b0;
            prog_counter <= 2'd0;
            prog_rw      <= 2'd0;
            shadow_rw    <= '0;
            cap_data     <= 16'h0000;
            cap_status   <= 8'h00;
            rsp_data     <= 16'h0000;
            rsp_status   <= 8'h00;
        end else begin
            if ((state == STROBE && next_state == STROBE) ||
                (state == RECOVER && next_state == RECOVER))
                cnt <= cnt + 4'd1;
            else
                cnt <= 4'd0;

            if (accept) begin
                step         <= 2'd0;
                seq_len      <= new_len;
                seq_wr       <= new_wr;
                seq_addr     <= new_addr;
                seq_dest     <= new_dest;
                seq_data     <= new_data;
                err_flag     <= new_err;
                has_read     <= !count_write;
                is_readback  <= (cmd_op == OP_READBACK);
                is_program   <= (cmd_op == OP_PROGRAM);
                prog_counter <= cmd_counter;
                prog_rw      <= cmd_rw;
                cap_data     <= 16'h0000;
                cap_status   <= 8'h00;
            end

            if (state == RECOVER && next_state == SETUP)
                step <= step + 2'd1;

            if (state == STROBE && strobe_done && !seq_wr[step]) begin
                case (seq_dest[step])
                    DEST_STATUS: cap_status      <= D_in;
                    DEST_LO:     cap_data[7:0]   <= D_in;
                    DEST_HI:     cap_data[15:8]  <= D_in;
                    default:     ;
                endcase
            end

            if (state == RECOVER && next_state == DONE) begin
                if (has_read)
                    rsp_data <= cap_data;
                if (is_readback)
                    rsp_status <= cap_status;
                if (is_program) begin
                    case (prog_counter)
                        2'd0:    shadow_rw[0] <= prog_rw;
                        2'd1:    shadow_rw[1] <= prog_rw;
                        2'd2:    shadow_rw[2] <= prog_rw;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pit_bus_master.sv
// Scoreboard bench for pit_bus_master: directed commands push expected bus
// cycles and responses; a negedge monitor pops and compares them.
module tb_pit_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_counter;
    logic [1:0]  cmd_rw;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_count;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_status;
    logic [1:0]  A;
    logic        CS;
    logic        RD;
    logic        WR;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;

    pit_bus_master #(.STROBE_CYCLES(2), .RECOVERY_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_counter(cmd_counter), .cmd_rw(cmd_rw),
        .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .A(A), .CS(CS), .RD(RD), .WR(WR), .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] data;
        logic [7:0]  status;
        int          lat;
    } rsp_t;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_t;

    rsp_t       exp_rsp[$];
    bus_t       exp_bus[$];
    logic [7:0] din_q[$];

    int   errors = 0;
    int   checks = 0;
    int   edges = 0;
    int   acc_edge = 0;
    bit   busy = 1'b0;
    logic prev_strobe = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_write(input logic [1:0] addr, input logic [7:0] data);
        bus_t b;
        b.wr = 1'b1; b.addr = addr; b.data = data;
        exp_bus.push_back(b);
    endtask

    task automatic push_read(input logic [1:0] addr, input logic [7:0] din);
        bus_t b;
        b.wr = 1'b0; b.addr = addr; b.data = 8'h00;
        exp_bus.push_back(b);
        din_q.push_back(din);
    endtask

    task automatic push_rsp(input logic err, input logic [15:0] data,
                            input logic [7:0] status, input int lat);
        rsp_t r;
        r.err = err; r.data = data; r.status = status; r.lat = lat;
        exp_rsp.push_back(r);
    endtask

    // Leaves cmd_valid high on return so a following call keeps it asserted
    // across the busy period of the command just accepted.
    task automatic apply_stimulus(input logic [1:0] op, input logic [1:0] counter,
                                  input logic [1:0] rw, input logic [2:0] mode,
                                  input logic bcd, input logic [15:0] count);
        int waited;
        cmd_op      = op;
        cmd_counter = counter;
        cmd_rw      = rw;
        cmd_mode    = mode;
        cmd_bcd     = bcd;
        cmd_count   = count;
        cmd_valid   = 1'b1;
        waited      = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check_output("accept_timeout", 32'(waited), 32'd0);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        edges++;
        if (cmd_valid && cmd_ready) begin
            check_output("accept_while_busy", 32'(busy), 32'd0);
            acc_edge = edges;
            busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        bus_t b;
        rsp_t r;
        logic strobe;
        strobe = !RD || !WR;
        if (strobe) begin
            check_output("rd_wr_overlap", 32'(!RD && !WR), 32'd0);
            check_output("cs_in_strobe", 32'(CS), 32'd0);
        end
        if (strobe && !prev_strobe) begin
            if (exp_bus.size() == 0) begin
                check_output("unexpected_strobe", {30'd0, RD, WR}, 32'd3);
            end else begin
                b = exp_bus.pop_front();
                check_output("bus_is_write", 32'(!WR), 32'(b.wr));
                check_output("bus_addr", 32'(A), 32'(b.addr));
                check_output("bus_d_oe", 32'(D_oe), 32'(b.wr));
                if (b.wr) begin
                    check_output("bus_d_out", 32'(D_out), 32'(b.data));
                end else if (din_q.size() != 0) begin
                    D_in = din_q.pop_front();
                end else begin
                    check_output("din_underflow", 32'(din_q.size()), 32'd1);
                end
            end
        end
        prev_strobe = strobe;
        if (rsp_valid) begin
            busy = 1'b0;
            if (exp_rsp.size() == 0) begin
                check_output("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                r = exp_rsp.pop_front();
                check_output("rsp_err", 32'(rsp_err), 32'(r.err));
                check_output("rsp_data", 32'(rsp_data), 32'(r.data));
                check_output("rsp_status", 32'(rsp_status), 32'(r.status));
                check_output("rsp_latency", 32'(edges + 1 - acc_edge), 32'(r.lat));
            end
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_rsp.size() != 0 || busy) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check_output("drain_rsp_queue", 32'(exp_rsp.size()), 32'd0);
        check_output("drain_bus_queue", 32'(exp_bus.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_counter = 2'b00;
        cmd_rw      = 2'b00;
        cmd_mode    = 3'b000;
        cmd_bcd     = 1'b0;
        cmd_count   = 16'h0000;
        D_in        = 8'h00;

        repeat (3) @(negedge clk);
        check_output("reset_cs", 32'(CS), 32'd1);
        check_output("reset_rd", 32'(RD), 32'd1);
        check_output("reset_wr", 32'(WR), 32'd1);
        check_output("reset_a", 32'(A), 32'd0);
        check_output("reset_d_out", 32'(D_out), 32'd0);
        check_output("reset_d_oe", 32'(D_oe), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_output("reset_rsp_data", 32'(rsp_data), 32'd0);
        check_output("reset_rsp_status", 32'(rsp_status), 32'd0);
        check_output("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Back-to-back directed commands with cmd_valid held high throughout.
        push_write(2'b11, 8'h76); push_write(2'b01, 8'h34); push_write(2'b01, 8'h12);
        push_rsp(1'b0, 16'h0000, 8'h00, 16);
        apply_stimulus(2'b00, 2'd1, 2'b11, 3'd3, 1'b0, 16'h1234);

        push_write(2'b11, 8'h40); push_read(2'b01, 8'h05); push_read(2'b01, 8'h10);
        push_rsp(1'b0, 16'h1005, 8'h00, 16);
        apply_stimulus(2'b01, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000);

        push_write(2'b11, 8'h14); push_write(2'b00, 8'hAB);
        push_rsp(1'b0, 16'h1005, 8'h00, 11);
        apply_stimulus(2'b00, 2'd0, 2'b01, 3'd2, 1'b0, 16'h00AB);

        push_write(2'b11, 8'hC2); push_read(2'b00, 8'h16); push_read(2'b00, 8'h09);
        push_rsp(1'b0, 16'h0009, 8'h16, 16);
        apply_stimulus(2'b10, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000);

        push_rsp(1'b1, 16'h0009, 8'h16, 1);
        apply_stimulus(2'b00, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1111);

        push_rsp(1'b1, 16'h0009, 8'h16, 1);
        apply_stimulus(2'b11, 2'd2, 2'b00, 3'd0, 1'b0, 16'h2222);

        push_write(2'b11, 8'hA1); push_write(2'b10, 8'h56);
        push_rsp(1'b0, 16'h0009, 8'h16, 11);
        apply_stimulus(2'b00, 2'd2, 2'b10, 3'd0, 1'b1, 16'h5600);

        push_write(2'b10, 8'h77);
        push_rsp(1'b0, 16'h0009, 8'h16, 6);
        apply_stimulus(2'b11, 2'd2, 2'b00, 3'd0, 1'b0, 16'h7700);

        push_write(2'b11, 8'h80); push_read(2'b10, 8'h3C);
        push_rsp(1'b0, 16'h3C00, 8'h16, 11);
        apply_stimulus(2'b01, 2'd2, 2'b00, 3'd0, 1'b0, 16'h0000);

        push_write(2'b11, 8'hC4); push_read(2'b01, 8'h27);
        push_read(2'b01, 8'h11); push_read(2'b01, 8'h22);
        push_rsp(1'b0, 16'h2211, 8'h27, 21);
        apply_stimulus(2'b10, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000);

        push_rsp(1'b1, 16'h2211, 8'h27, 1);
        apply_stimulus(2'b00, 2'd1, 2'b00, 3'd1, 1'b0, 16'h3333);

        push_write(2'b11, 8'h00); push_read(2'b00, 8'h5A);
        push_rsp(1'b0, 16'h005A, 8'h27, 11);
        apply_stimulus(2'b01, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000);

        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of the control-word strobe of a PROGRAM.
        push_write(2'b11, 8'h76);
        apply_stimulus(2'b00, 2'd1, 2'b11, 3'd3, 1'b0, 16'h1234);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_output("abort_in_strobe", 32'(WR), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_wr", 32'(WR), 32'd1);
        check_output("abort_rd", 32'(RD), 32'd1);
        check_output("abort_cs", 32'(CS), 32'd1);
        check_output("abort_d_oe", 32'(D_oe), 32'd0);
        check_output("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        busy = 1'b0;
        din_q.delete();
        rst = 1'b0;
        @(negedge clk);

        push_rsp(1'b1, 16'h0000, 8'h00, 1);
        apply_stimulus(2'b11, 2'd1, 2'b00, 3'd0, 1'b0, 16'hBEEF);
        cmd_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pit_bus_master.md
PIT_BUS_MASTER -- requirements
Module: pit_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, number of clocks RD or WR is held low per bus cycle (legal 1-15).
REQ-002 Parameter RECOVERY_CYCLES, default 1, number of clocks CS is high between bus cycles (legal 1-15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted on a clock where cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  input  2  00 PROGRAM, 01 LATCH_READ, 10 READBACK, 11 WRITE_COUNT.
REQ-008 cmd_counter  input  2  target counter 0-2; 3 is illegal.
REQ-009 cmd_rw  input  2  access format: 01 LSB, 10 MSB, 11 LSB then MSB; used by PROGRAM only.
REQ-010 cmd_mode  input  3  counter mode; used by PROGRAM only.
REQ-011 cmd_bcd  input  1  BCD select; used by PROGRAM only.
REQ-012 cmd_count  input  16  count value for PROGRAM and WRITE_COUNT.
REQ-013 rsp_valid  output  1  one-clock completion pulse.
REQ-014 rsp_err  output  1  command rejected; valid with rsp_valid.
REQ-015 rsp_data  output  16  count read back; valid with rsp_valid.
REQ-016 rsp_status  output  8  status byte from READBACK; valid with rsp_valid.
REQ-017 A  output  2  8254 address; 11 selects the control register.
REQ-018 CS  output  1  chip select, active low.
REQ-019 RD  output  1  read strobe, active low.
REQ-020 WR  output  1  write strobe, active low.
REQ-021 D_out  output  8  write data.
REQ-022 D_oe  output  1  D_out drive enable.
REQ-023 D_in  input  8  read data from the 8254.

Function
REQ-024 States SHALL be IDLE, SETUP, STROBE, HOLD, RECOVER and DONE; a step index SHALL select the next byte of the command sequence.
REQ-025 cmd_ready SHALL be high only in IDLE with rst low.
REQ-026 Each bus cycle SHALL run as follows:
- SETUP (1 clk): CS=0, A valid, RD=WR=1; for writes, D_oe=1 with D_out valid.
- STROBE (STROBE_CYCLES clks): WR=0 for writes, RD=0 for reads.
- HOLD (1 clk): strobe high; CS, A and D_out held.
- RECOVER (RECOVERY_CYCLES clks): CS=1, D_oe=0.
REQ-027 RD and WR SHALL never be low in the same clock; D_oe SHALL be 0 during reads.
REQ-028 D_in SHALL be sampled at the posedge ending the last STROBE clock of a read.
REQ-029 PROGRAM SHALL write control word {cmd_counter, cmd_rw, cmd_mode, cmd_bcd} to A=11, then count bytes to A=cmd_counter in the cmd_rw order. It SHALL then store cmd_rw in shadow_rw[cmd_counter].
REQ-030 LATCH_READ SHALL write {cmd_counter, 2'b00, 4'b0000} to A=11, then read count bytes from A=cmd_counter in shadow_rw order.
REQ-031 READBACK SHALL write {2'b11, 1'b0, 1'b0, select, 1'b0} to A=11, where select is 3 bits with only bit cmd_counter set (control word bit cmd_counter+1). It SHALL then read one status byte into rsp_status, then count bytes in shadow_rw order.
REQ-032 WRITE_COUNT SHALL write the cmd_count bytes to A=cmd_counter in shadow_rw order, with no control word.
REQ-033 Read assembly: LSB-only gives {8'h00, lsb}; MSB-only gives {msb, 8'h00}; two bytes give {second, first}.
REQ-034 Errors:
- Causes: cmd_counter==3; PROGRAM with cmd_rw==00; LATCH_READ, READBACK or WRITE_COUNT with shadow_rw==00.
- Response: no bus cycle; rsp_valid=1 and rsp_err=1 one clock after acceptance.
REQ-035 Normal completion SHALL pulse rsp_valid, with rsp_err=0, in the clock after the final RECOVER clock, then return to IDLE.
REQ-036 rsp_data and rsp_status SHALL hold their values until the next completion; write-only commands SHALL leave them unchanged.
REQ-037 Latency with defaults: 5 clocks per bus cycle; PROGRAM with rw=11 asserts rsp_valid 16 clocks after acceptance.

Reset
REQ-038 rst SHALL force the following on the next posedge, including mid-bus-cycle:
- CS=RD=WR=1, A=00, D_out=00, D_oe=0.
- rsp_valid=0, rsp_err=0, rsp_data=0000, rsp_status=00, cmd_ready=0 while rst is high.
- state IDLE; all shadow_rw cleared to 00.
REQ-039 A command aborted by reset SHALL produce no response.

Verification
REQ-040 PROGRAM counter1, rw=11, mode=3, bcd=0, count=0x1234 -> writes 0x76 to A=11, 0x34 then 0x12 to A=01; rsp_valid at +16 clocks, rsp_err=0.
REQ-041 After REQ-040, LATCH_READ counter1 with D_in model returning 0x05 then 0x10 -> writes 0x40 to A=11, two reads at A=01; rsp_data=0x1005.
REQ-042 READBACK counter0 after PROGRAM rw=01, with status byte 0x16 and count byte 0x09 -> writes 0xC2 to A=11; rsp_status=0x16, rsp_data=0x0009.
REQ-043 cmd_counter=3, or WRITE_COUNT to an unprogrammed counter -> CS stays 1; rsp_valid=1 and rsp_err=1 one clock after acceptance.
REQ-044 rst asserted during the STROBE of a PROGRAM -> next clock WR=1, CS=1, D_oe=0, no rsp_valid, shadow_rw cleared, so a following WRITE_COUNT returns rsp_err=1.
REQ-045 Checker on all tests: no clock with RD=0 and WR=0; CS=0 throughout every strobe; cmd_valid held high across a busy period -> accepted only in IDLE.
